alu_arbiter: RTL and testbench

Shares the single 16-bit ADD/XOR `ALU` datapath between `NUM_REQ` requesters, for example the main execute stage and an address or auxiliary unit. A round-robin grant selects at most one request per cycle and issues it to the ALU. The result is captured in a one-entry registered response stage, tagged with the requester ID. Every request and the response use valid/ready handshakes, so the block sits between issue logic and writeback and absorbs writeback stalls.

---
 rtl/alu_pkg.sv | 17 +
 rtl/ALU.sv | 18 +
 rtl/rr_arbiter.sv | 47 ++++
 rtl/alu_arbiter.sv | 111 +++++++++++
 tb/tb_alu_arbiter.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, opcode encodings and the
// registered response payload used by the ALU arbiter.
package alu_pkg;

    localparam int ALU_W = 16;

    localparam logic ALU_OP_ADD = 1'b0;
    localparam logic ALU_OP_XOR = 1'b1;

    // The id field is wide enough for the largest legal requester count (4).
    typedef struct packed {
        logic [ALU_W-1:0] result;
        logic             carry;
        logic [1:0]       id;
    } alu_rsp_t;

endpackage

// File: rtl/ALU.sv
// Shared 16-bit ADD/XOR datapath; purely combinational.
module ALU
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    input  logic             op,
    output logic [ALU_W-1:0] result,
    output logic             carry
);

    logic [ALU_W:0] sum;

    assign sum    = {1'b0, a} + {1'b0, b};
    assign result = (op == ALU_OP_XOR) ? (a ^ b) : sum[ALU_W-1:0];
    assign carry  = (op == ALU_OP_ADD) ? sum[ALU_W] : 1'b0;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first set request at or after rr_ptr
// when advance is high, then moves the pointer just past the winner.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               granted
);

    logic [ID_W-1:0] rr_ptr;

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        int j;
        grant   = '0;
        idx     = '0;
        granted = 1'b0;
        j       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (advance && !granted && req[j]) begin
                granted  = 1'b1;
                grant[j] = 1'b1;
                idx      = ID_W'(j);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (granted) begin
            rr_ptr <= (int'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NUM_REQ valid/ready requesters with a one-entry
// registered response. Define ALU_ARB_STATS_EN to build per-requester grant counters.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*ALU_W-1:0] req_a,
    input  logic [NUM_REQ*ALU_W-1:0] req_b,
    input  logic [NUM_REQ-1:0]       req_op,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [ALU_W-1:0]         rsp_result,
    output logic                     rsp_carry,
    output logic [NUM_REQ*ALU_W-1:0] stat_grants
);

    logic               can_issue;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               granted;
    logic [ALU_W-1:0]   alu_a;
    logic [ALU_W-1:0]   alu_b;
    logic               alu_op;
    logic [ALU_W-1:0]   alu_result;
    logic               alu_carry;
    alu_rsp_t           rsp_q;

    // Reset blocks issue so nothing is accepted on a reset cycle.
    assign can_issue = (!rsp_valid || rsp_ready) && !rst;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .advance (can_issue),
        .grant   (grant),
        .idx     (grant_idx),
        .granted (granted)
    );

    assign req_ready = grant;

    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = ALU_OP_ADD;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                alu_a  = req_a[i*ALU_W +: ALU_W];
                alu_b  = req_b[i*ALU_W +: ALU_W];
                alu_op = req_op[i];
            end
        end
    end

    ALU u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_result),
        .carry  (alu_carry)
    );

    // A grant always loads, which covers drain-and-fill in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_q     <= '0;
        end else if (granted) begin
            rsp_valid    <= 1'b1;
            rsp_q.result <= alu_result;
            rsp_q.carry  <= alu_carry;
            rsp_q.id     <= 2'(grant_idx);
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    assign rsp_result = rsp_q.result;
    assign rsp_carry  = rsp_q.carry;
    assign rsp_id     = ID_W'(rsp_q.id);

`ifdef ALU_ARB_STATS_EN
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
        logic [ALU_W-1:0] cnt;

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt <= '0;
            end else if (grant[i] && cnt != {ALU_W{1'b1}}) begin
                cnt <= cnt + 1'b1;
            end
        end

        assign stat_grants[i*ALU_W +: ALU_W] = cnt;
    end
`else
    assign stat_grants = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with two requesters.
module tb_alu_arbiter;

    localparam int NUM_REQ = 2;
    localparam int ID_W    = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*16-1:0] req_a;
    logic [NUM_REQ*16-1:0] req_b;
    logic [NUM_REQ-1:0]   req_op;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic [15:0]          rsp_result;
    logic                 rsp_carry;
    logic [NUM_REQ*16-1:0] stat_grants;

    int n_pass  = 0;
    int n_total = 0;

    alu_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_op      (req_op),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_result  (rsp_result),
        .rsp_carry   (rsp_carry),
        .stat_grants (stat_grants)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [15:0] a,
                           input logic [15:0] b, input logic op);
        req_valid[i]       = v;
        req_a[i*16 +: 16]  = a;
        req_b[i*16 +: 16]  = b;
        req_op[i]          = op;
    endtask

    task automatic check_rsp(input string tag, input logic [15:0] res,
                             input logic cy, input logic [1:0] id);
        check({tag, "_valid"},  32'(rsp_valid),  32'h1);
        check({tag, "_result"}, 32'(rsp_result), 32'(res));
        check({tag, "_carry"},  32'(rsp_carry),  32'(cy));
        check({tag, "_id"},     32'(rsp_id),     32'(id));
    endtask

    logic [15:0] exp_res [4] = '{16'h0003, 16'h0FFF, 16'h0003, 16'h0FFF};

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 1'b1;

        // Reset: nothing accepted even with requests pending
        tick();
        set_req(0, 1'b1, 16'h1111, 16'h2222, 1'b0);
        set_req(1, 1'b1, 16'h3333, 16'h4444, 1'b1);
        #1;
        check("rst_ready", 32'(req_ready), 32'h0);
        tick();
        check("rst_valid", 32'(rsp_valid), 32'h0);
        check("rst_stats", 32'(stat_grants), 32'h0);
        check("rst_result", 32'(rsp_result), 32'h0);
        req_valid = '0;
        rst       = 1'b0;
        tick();
        check("idle_valid", 32'(rsp_valid), 32'h0);
        check("idle_ready", 32'(req_ready), 32'h0);

        // Single ADD with carry out
        set_req(0, 1'b1, 16'hFFFF, 16'h0001, 1'b0);
        #1;
        check("add_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        check_rsp("add", 16'h0000, 1'b1, 2'd0);

        // XOR from requester 1
        set_req(1, 1'b1, 16'hA5A5, 16'h0FF0, 1'b1);
        #1;
        check("xor_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        check_rsp("xor", 16'hAA55, 1'b0, 2'd1);
        tick();
        check("drain_valid", 32'(rsp_valid), 32'h0);

        // Contention: strict alternation, back-to-back responses
        set_req(0, 1'b1, 16'h0001, 16'h0002, 1'b0);
        set_req(1, 1'b1, 16'h00F0, 16'h0F0F, 1'b1);
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("cont_ready%0d", k), 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
            tick();
            check_rsp($sformatf("cont%0d", k), exp_res[k], 1'b0, 2'(k % 2));
        end

        // Backpressure: held response stays put, no grant
        req_valid = '0;
        set_req(0, 1'b1, 16'h1234, 16'h1111, 1'b0);
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("stall_ready%0d", k), 32'(req_ready), 32'h0);
            tick();
            check_rsp($sformatf("stall%0d", k), 16'h0FFF, 1'b0, 2'd1);
        end
        rsp_ready = 1'b1;
        #1;
        check("unstall_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        check_rsp("unstall", 16'h2345, 1'b0, 2'd0);

        // Reset while a response is held under stall
        set_req(1, 1'b1, 16'h0001, 16'h0001, 1'b0);
        tick();
        req_valid = '0;
        check_rsp("prerst", 16'h0002, 1'b0, 2'd1);
        set_req(0, 1'b1, 16'h0005, 16'h0005, 1'b0);
        tick();
        req_valid = '0;
        rsp_ready = 1'b0;
        check("prerst2_id", 32'(rsp_id), 32'h0);
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        rsp_ready = 1'b1;
        check("midrst_valid", 32'(rsp_valid), 32'h0);
        check("midrst_stats", 32'(stat_grants), 32'h0);
        // Pointer was at 1 before reset; a cleared pointer favours requester 0
        set_req(0, 1'b1, 16'h0010, 16'h0020, 1'b0);
        set_req(1, 1'b1, 16'h0100, 16'h0200, 1'b0);
        #1;
        check("midrst_ptr", 32'(req_ready), 32'h1);

        // Grant tally: 5 to req0, 3 to req1
        for (int k = 0; k < 6; k++) tick();
        check_rsp("tally_last", 16'h0300, 1'b0, 2'd1);
        req_valid[1] = 1'b0;
        for (int k = 0; k < 2; k++) tick();
        check_rsp("tally_req0", 16'h0030, 1'b0, 2'd0);
        req_valid = '0;
        tick();
`ifdef ALU_ARB_STATS_EN
        check("stats", 32'(stat_grants), 32'h0003_0005);
`else
        check("stats", 32'(stat_grants), 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
